// File: rtl/input_conditioner.sv
// Per-channel input conditioner: source select, 2-flop sync, debounce, rise detect,
// mode-change blanking guard and a small event FIFO for rising edges.
module input_conditioner #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 33000,
  parameter int GUARD_CYCLES    = 1024,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   sensor_mode,
  input  logic [N_CH-1:0]                        sensor_in,
  input  logic [N_CH-1:0]                        button_in,
  output logic [N_CH-1:0]                        level,
  output logic [N_CH-1:0]                        rise,
  output logic                                   evt_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] evt_ch,
  input  logic                                   evt_ready,
  output logic                                   overflow,
  input  logic                                   overflow_clr,
  output logic                                   guard_active
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GD_W  = $clog2(GUARD_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GD_W-1:0]  GD_LOAD   = GD_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  logic            mode_s1, mode_s, mode_prev;
  logic [N_CH-1:0] sensor_s1, sensor_s, button_s1, button_s;
  logic [N_CH-1:0] sample;

  logic [GD_W-1:0] guard_cnt;
  logic            mode_change, guard;

  logic [N_CH-1:0] level_q, rise_q, level_next;
  logic [DB_W-1:0] db_cnt  [N_CH];
  logic [DB_W-1:0] db_next [N_CH];

  logic [N_CH-1:0] pend_q, pend_eff, push_mask;
  logic [CH_W-1:0] push_sel;
  logic            push, pop, room, ovf_set;

  logic [CH_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_s1   <= 1'b0;
      mode_s    <= 1'b0;
      mode_prev <= 1'b0;
      sensor_s1 <= '0;
      sensor_s  <= '0;
      button_s1 <= '0;
      button_s  <= '0;
    end else begin
      mode_s1   <= sensor_mode;
      mode_s    <= mode_s1;
      mode_prev <= mode_s;
      sensor_s1 <= sensor_in;
      sensor_s  <= sensor_s1;
      button_s1 <= button_in;
      button_s  <= button_s1;
    end
  end

  assign sample      = mode_s ? sensor_s : button_s;
  assign mode_change = mode_s ^ mode_prev;
  assign guard       = mode_change | (guard_cnt != '0);

  // Guard down-counter; a mode change during blanking restarts the full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_cnt <= '0;
    end else if (mode_change) begin
      guard_cnt <= GD_LOAD;
    end else if (guard_cnt != '0) begin
      guard_cnt <= guard_cnt - GD_W'(1);
    end
  end

  always_comb begin
    level_next = level_q;
    for (int i = 0; i < N_CH; i++) begin
      db_next[i] = '0;
      if (sample[i] != level_q[i]) begin
        if (db_cnt[i] == DB_LAST) level_next[i] = ~level_q[i];
        else                      db_next[i]    = db_cnt[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      rise_q  <= '0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else if (guard) begin
      level_q <= '0;
      rise_q  <= '0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else begin
      level_q <= level_next;
      rise_q  <= level_next & ~level_q;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= db_next[i];
    end
  end

  // Masking covers the detection cycle, before the registers have been cleared.
  assign level        = level_q & {N_CH{~guard}};
  assign rise         = rise_q  & {N_CH{~guard}};
  assign guard_active = guard;

  assign pend_eff = guard ? '0 : (pend_q | rise);
  assign ovf_set  = |(rise & pend_q);
  assign pop      = evt_valid & evt_ready;
  assign room     = (fifo_cnt != FIFO_FULL) | pop;
  assign push     = (|pend_eff) & room;

  // Descending scan so the lowest set pending bit wins.
  always_comb begin
    push_sel  = '0;
    push_mask = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_eff[i]) begin
        push_sel     = CH_W'(i);
        push_mask    = '0;
        push_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      overflow <= 1'b0;
    end else begin
      pend_q <= push ? (pend_eff & ~push_mask) : pend_eff;
      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_sel;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign evt_valid = (fifo_cnt != '0);
  assign evt_ch    = mem[rd_ptr];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: N_CH=2, debounce 4, guard 8, FIFO depth 4.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor_mode = 1'b0;
  logic [1:0] sensor_in = 2'b00;
  logic [1:0] button_in = 2'b00;
  logic       evt_ready = 1'b1;
  logic       overflow_clr = 1'b0;
  logic [1:0] level, rise;
  logic       evt_valid, overflow, guard_active;
  logic [0:0] evt_ch;

  int checks = 0;
  int errors = 0;
  int n;
  logic seen_lvl, seen_evt, g_ok;
  logic [14:0] pat;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .GUARD_CYCLES(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sensor_mode(sensor_mode),
    .sensor_in(sensor_in), .button_in(button_in),
    .level(level), .rise(rise), .evt_valid(evt_valid), .evt_ch(evt_ch),
    .evt_ready(evt_ready), .overflow(overflow), .overflow_clr(overflow_clr),
    .guard_active(guard_active)
  );

  task automatic step(input int cyc);
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    chk("rst_level", 32'(level), 0);
    chk("rst_rise", 32'(rise), 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_ch", 32'(evt_ch), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_guard", 32'(guard_active), 0);
    reset_n = 1'b1;
    step(3);

    // clean press on ch0
    button_in[0] = 1'b1;
    step(5);
    chk("press_level_early", 32'(level), 0);
    step(1);
    chk("press_level", 32'(level), 32'h1);
    chk("press_rise", 32'(rise), 32'h1);
    chk("press_valid_early", 32'(evt_valid), 0);
    step(1);
    chk("press_rise_width", 32'(rise), 0);
    chk("press_evt_valid", 32'(evt_valid), 1);
    chk("press_evt_ch", 32'(evt_ch), 0);
    step(1);
    chk("press_popped", 32'(evt_valid), 0);
    button_in[0] = 1'b0;
    step(8);
    chk("release_level", 32'(level), 0);
    chk("release_no_evt", 32'(evt_valid), 0);

    // bounce on ch1: high 3, low 1, high 3, low
    pat = 15'h0077;
    seen_lvl = 1'b0;
    seen_evt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      button_in[1] = pat[i];
      step(1);
      seen_lvl |= level[1];
      seen_evt |= evt_valid | rise[1];
    end
    chk("bounce_level", 32'(seen_lvl), 0);
    chk("bounce_event", 32'(seen_evt), 0);

    // simultaneous rise with consumer stalled
    evt_ready = 1'b0;
    button_in = 2'b11;
    step(6);
    chk("sim_rise", 32'(rise), 32'h3);
    step(1);
    chk("sim_valid", 32'(evt_valid), 1);
    chk("sim_head0", 32'(evt_ch), 0);
    step(1);
    chk("sim_head_stable", 32'(evt_ch), 0);
    chk("sim_overflow", 32'(overflow), 0);
    evt_ready = 1'b1;
    step(1);
    chk("sim_second_valid", 32'(evt_valid), 1);
    chk("sim_head1", 32'(evt_ch), 1);
    step(1);
    chk("sim_drained", 32'(evt_valid), 0);
    button_in = 2'b00;
    step(8);

    // overflow: six ch0 presses, consumer stalled
    evt_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      button_in[0] = 1'b1;
      step(6);
      if (p == 5) overflow_clr = 1'b1;
      chk("ovf_before_rise", 32'(overflow), 0);
      step(1);
      overflow_clr = 1'b0;
      chk("ovf_after_rise", 32'(overflow), (p == 5) ? 1 : 0);
      button_in[0] = 1'b0;
      step(7);
    end
    chk("ovf_head_valid", 32'(evt_valid), 1);
    chk("ovf_head_ch", 32'(evt_ch), 0);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    evt_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (evt_valid) n++;
      step(1);
    end
    chk("ovf_event_count", 32'(n), 5);

    // mode change while level[0]=1, FIFO holding one event
    evt_ready = 1'b0;
    button_in[0] = 1'b1;
    sensor_in[0] = 1'b1;
    step(7);
    chk("mode_pre_level", 32'(level), 32'h1);
    chk("mode_pre_valid", 32'(evt_valid), 1);
    sensor_mode = 1'b1;
    step(2);
    g_ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      g_ok &= guard_active & (level == 2'b00) & (rise == 2'b00);
      step(1);
    end
    chk("guard_window", 32'(g_ok), 1);
    chk("guard_end", 32'(guard_active), 0);
    chk("guard_fifo_kept", 32'(evt_valid), 1);
    chk("guard_fifo_ch", 32'(evt_ch), 0);
    step(3);
    chk("guard_rise_early", 32'(rise), 0);
    step(1);
    chk("guard_rise", 32'(rise), 32'h1);
    chk("guard_level", 32'(level), 32'h1);
    evt_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (evt_valid) n++;
      step(1);
    end
    chk("guard_event_count", 32'(n), 2);

    // async reset mid-burst
    evt_ready = 1'b0;
    sensor_in[1] = 1'b1;
    step(7);
    chk("burst_level", 32'(level), 32'h3);
    chk("burst_head_ch", 32'(evt_ch), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_rise", 32'(rise), 0);
    chk("arst_valid", 32'(evt_valid), 0);
    chk("arst_ch", 32'(evt_ch), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_guard", 32'(guard_active), 0);
    #4;
    reset_n = 1'b1;
    evt_ready = 1'b1;
    step(1);
    chk("arst_post_valid", 32'(evt_valid), 0);
    chk("arst_post_level", 32'(level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised per-channel conditioner for the game-control inputs (jump, duck, and future actions). It sits between the raw control sources and `runner` in the 33 MHz domain. For each channel it selects the sensor or button source, synchronises and debounces it, and emits level and rising-edge outputs. It also queues edge events in a small FIFO so no action is lost while the game loop is busy. Switching between sensor and button mode blanks all channels for a guard period, which suppresses spurious actions.

## Interface

Parameters:
- `N_CH`, default 2: number of channels (≥1).
- `DEBOUNCE_CYCLES`, default 33000: consecutive differing samples needed to flip a level (≥1).
- `GUARD_CYCLES`, default 1024: blanking length after a mode change (≥1).
- `FIFO_DEPTH`, default 8: event queue depth (power of 2, ≥2).

Ports:
- `clk` in 1: the single clock for the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `sensor_mode` in 1: 1 selects `sensor_in`, 0 selects `button_in`. Asynchronous to the block; it is synchronised internally.
- `sensor_in` in N_CH: raw sensor-derived actions, active-high.
- `button_in` in N_CH: raw button actions, active-high. Polarity is fixed upstream.
- `level` out N_CH: debounced, held state per channel.
- `rise` out N_CH: one-cycle pulse on each 0→1 transition of `level`.
- `evt_valid` out 1: FIFO head is valid.
- `evt_ch` out max(1,$clog2(N_CH)): channel index at the FIFO head.
- `evt_ready` in 1: consumer accepts the head.
- `overflow` out 1: sticky flag, set when an event is lost.
- `overflow_clr` in 1: clears `overflow`.
- `guard_active` out 1: high while the mode-change blanking is in progress.

## Operation

**Input stage**
- `sensor_mode`, `sensor_in` and `button_in` each pass through two flip-flops.
- The per-channel sample is `mode_s ? sensor_s[i] : button_s[i]`, where `mode_s` and the `_s` signals are the synchronised values.

**Debounce (per channel)**
- The counter clears whenever `sample == level`.
- While `sample != level`, the counter increments each cycle.
- When `sample != level` and count == DEBOUNCE_CYCLES−1, `level` toggles and the counter clears.
- With DEBOUNCE_CYCLES=1, `level` follows the sample with one cycle of delay.
- `rise[i]` = `level[i]` transitioning 0→1, registered. A fall generates no event.

**Mode guard**
- A mode change is detected when `mode_s` differs from its previous value.
- On the detection cycle, the guard counter loads GUARD_CYCLES. During that cycle and every cycle while the counter is nonzero:
  - all `level` bits are forced to 0 and all debounce counters to 0;
  - `rise` is held at 0 and the pending vector is cleared;
  - `guard_active` is 1.
- The guard counter decrements to 0; debouncing resumes the cycle after it reaches 0.
- A further mode change during the guard period reloads the counter.
- The FIFO contents are preserved across a mode change.

**Event path**
- The pending vector is updated each cycle as `pending | rise`.
- Each cycle, the lowest set pending bit is pushed as its index, provided the FIFO has room. Its pending bit clears in the same cycle.
- The FIFO has room when its count < FIFO_DEPTH or a pop occurs in the same cycle.
- A pop occurs when `evt_valid && evt_ready`.
- If `rise[i]` arrives while `pending[i]` is already 1, the events coalesce and `overflow` is set.
- `overflow` remains set until `overflow_clr`. If set and clear occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. The count saturates cleanly at full and at empty.

## Timing

- Reset values:
  - outputs: `level`=0, `rise`=0, `evt_valid`=0, `evt_ch`=0, `overflow`=0, `guard_active`=0;
  - internal state: sync flops, `mode_s` history, counters, pending vector and FIFO pointers all 0.
- After reset, `mode_s` starts at 0. If `sensor_mode`=1 at reset release, a guard period starts.
- Input latency: if a raw input goes high and stays stable from edge t, then `level` and `rise` assert at edge t+2+DEBOUNCE_CYCLES.
- Event latency: with pending and FIFO empty, `evt_valid` asserts one cycle after `rise`, and `evt_ch` is valid with it.
- `evt_ch` is stable while `evt_valid && !evt_ready`.
- Reset assertion mid-operation clears the FIFO, pending vector and guard immediately, without waiting for a clock edge.

## Test plan

Bench parameters: N_CH=2, DEBOUNCE_CYCLES=4, GUARD_CYCLES=8, FIFO_DEPTH=4, `evt_ready`=1 unless a scenario says otherwise.

1. **Clean press:** `button_in[0]` rises at t and holds. Required: `level[0]` and `rise[0]` at t+6, `rise[0]` one cycle wide, `evt_valid` with `evt_ch`=0 at t+7.
2. **Bounce:** `button_in[1]` toggles high 3 cycles, low 1, high 3, low. Required: no `level[1]` change and no event.
3. **Simultaneous rise, FIFO stall:** both channels rise in the same cycle with `evt_ready`=0. Required: events ch0 then ch1 on consecutive cycles, count=2, `overflow`=0.
4. **Overflow:** `evt_ready`=0 while 6 distinct ch0 presses occur. Required: FIFO holds 4 events, 1 event pending, `overflow` set on the 6th rise. `overflow_clr` asserted in the same cycle as a set leaves `overflow`=1.
5. **Mode change:** `sensor_mode` toggles while `level[0]`=1. Required:
   - `guard_active` high for 9 cycles (detection cycle + 8), `level` forced 0 throughout, no `rise`;
   - a held `sensor_in[0]`=1 produces `rise[0]` 4 cycles after `guard_active` falls;
   - existing FIFO entries are retained.
6. **Async reset:** `reset_n` low for half a cycle mid-burst. Required: all outputs 0 immediately, and `evt_valid`=0 after release.
